// File: rtl/ram16.sv
// ram16: single-port 16-bit word RAM with a registered read port and a
// write-count wrap flag (FULL pulses once every DEPTH accepted writes).
//
// Optional feature macro: RAM16_MEM_CLEAR_EN
//   defined   - RST also clears every RAM word to 16'h0000.
//   undefined - the array has no reset, so a RAM macro can be inferred;
//               contents are undefined until written.
module ram16 #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [15:0]           Di,
    output logic [15:0]           Do,
    output logic                  FULL
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // The counter value that completes a wrap (DEPTH-1 in ADDR_WIDTH bits).
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    // Storage; the name RAM is kept so benches can peek at it hierarchically.
    logic [15:0] RAM [DEPTH];

    logic [15:0]           do_q;
    logic [15:0]           do_d;
    logic                  full_q;
    logic                  full_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    // Next-state for read data, write counter and wrap pulse.
    // The read samples the array before this edge's write lands, which gives
    // read-before-write on a same-address READ+WRITE.
    always_comb begin
        do_d   = do_q;
        cnt_d  = cnt_q;
        full_d = 1'b0;
        if (READ) begin
            do_d = RAM[A];
        end
        if (WRITE) begin
            // Natural ADDR_WIDTH-bit overflow wraps the count modulo DEPTH.
            cnt_d  = cnt_q + 1'b1;
            full_d = (cnt_q == CNT_LAST);
        end
    end

    // Control/output registers with asynchronous active-high reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            do_q   <= 16'h0000;
            full_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            do_q   <= do_d;
            full_q <= full_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef RAM16_MEM_CLEAR_EN
    // Memory array write port; reset clears every word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                RAM[i] <= 16'h0000;
            end
        end else if (WRITE) begin
            RAM[A] <= Di;
        end
    end
`else
    // Memory array write port; no reset so the array maps onto a RAM macro.
    always_ff @(posedge CLK) begin
        if (!RST && WRITE) begin
            RAM[A] <= Di;
        end
    end
`endif

    assign Do   = do_q;
    assign FULL = full_q;

endmodule

// File: tb/tb_ram16.sv
// Bench for ram16: directed steps from the test plan followed by random
// traffic, all checked against a behavioural word-array model.
module tb_ram16;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          CLK;
    logic          RST;
    logic          READ;
    logic          WRITE;
    logic [AW-1:0] A;
    logic [15:0]   Di;
    logic [15:0]   Do;
    logic          FULL;

    ram16 #(.ADDR_WIDTH(AW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .READ  (READ),
        .WRITE (WRITE),
        .A     (A),
        .Di    (Di),
        .Do    (Do),
        .FULL  (FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: memory contents, which words are defined, expected
    // outputs and the number of writes accepted since the last reset.
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [15:0] m_do;
    bit          m_do_known;
    logic        m_full;
    int          m_writes;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_do       = 16'h0000;
        m_do_known = 1'b1;
        m_full     = 1'b0;
        m_writes   = 0;
`ifdef RAM16_MEM_CLEAR_EN
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]   = 16'h0000;
            m_known[k] = 1'b1;
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        if (m_do_known) chk({tag, "/Do"}, Do, m_do);
        chk({tag, "/FULL"}, {15'd0, FULL}, {15'd0, m_full});
    endtask

    // One clock: drive inputs, take the edge, advance the model, check #1 later.
    task automatic cycle(input string tag, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [15:0] data);
        READ  = rd;
        WRITE = wr;
        A     = addr;
        Di    = data;
        @(posedge CLK);
        if (rd) begin
            m_do       = m_mem[addr];
            m_do_known = m_known[addr];
        end
        m_full = 1'b0;
        if (wr) begin
            m_mem[addr]   = data;
            m_known[addr] = 1'b1;
            m_writes++;
            m_full = (m_writes % DEPTH) == 0;
        end
        #1;
        check_outputs(tag);
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    int full_pulses;
    int full_rises;
    logic prev_full;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]   = 16'h0000;
            m_known[k] = 1'b0;
        end
        READ  = 1'b0;
        WRITE = 1'b0;
        A     = '0;
        Di    = '0;

        // Reset for two cycles, released between edges.
        RST = 1'b1;
        #2;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_outputs("reset");
        RST = 1'b0;

        cycle("rd_unwritten5", 1'b1, 1'b0, 3'd5, 16'h0);

        // Write/read loop with FULL pulse accounting.
        full_pulses = 0;
        full_rises  = 0;
        prev_full   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cycle("loop_wr", 1'b0, 1'b1, AW'(i % 8), 16'hB000 + 16'(i));
            if (FULL === 1'b1) full_pulses++;
            if (FULL === 1'b1 && prev_full === 1'b0) full_rises++;
            prev_full = FULL;
            chk("loop_full_after_write", {15'd0, FULL}, {15'd0, ((i + 1) % 8 == 0)});
            cycle("loop_rd", 1'b1, 1'b0, AW'(i % 8), 16'h0);
            chk("loop_rd_value", Do, 16'hB000 + 16'(i));
            if (FULL === 1'b1) full_pulses++;
            prev_full = FULL;
        end
        chk("full_rises", 16'(full_rises), 16'd4);
        chk("full_high_cycles", 16'(full_pulses), 16'd4);

        for (int k = 0; k < DEPTH; k++) begin
            chk("dump", dut.RAM[k], 16'hB018 + 16'(k));
        end

        // Read-before-write on the same address.
        cycle("rbw_pre", 1'b0, 1'b1, 3'd2, 16'h1111);
        cycle("rbw", 1'b1, 1'b1, 3'd2, 16'h2222);
        chk("rbw_old", Do, 16'h1111);
        cycle("rbw_after", 1'b1, 1'b0, 3'd2, 16'h0);
        chk("rbw_new", Do, 16'h2222);

        // Do holds across idle cycles and a write to the read address.
        cycle("hold_wr", 1'b0, 1'b1, 3'd1, 16'hB001);
        cycle("hold_rd", 1'b1, 1'b0, 3'd1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("hold_idle", 1'b0, 1'b0, 3'd0, 16'h0);
            chk("hold_idle_do", Do, 16'hB001);
        end
        cycle("hold_wr2", 1'b0, 1'b1, 3'd1, 16'h5A5A);
        chk("hold_after_wr", Do, 16'hB001);
        cycle("hold_rd2", 1'b1, 1'b0, 3'd1, 16'h0);
        chk("hold_new", Do, 16'h5A5A);

        // Reset mid-sequence: start from a clean count, 5 writes, async reset.
        RST = 1'b1;
        #1;
        model_reset();
        RST = 1'b0;
        cycle("mid_rd", 1'b1, 1'b0, 3'd1, 16'h0);
        for (int i = 0; i < 5; i++) begin
            cycle("mid_wr", 1'b0, 1'b1, AW'(i), 16'hC000 + 16'(i));
        end
        cycle("mid_rd2", 1'b1, 1'b0, 3'd4, 16'h0);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_async_rst");
        chk("mid_async_do", Do, 16'h0000);
        // Strobes during reset are ignored.
        READ  = 1'b1;
        WRITE = 1'b1;
        A     = 3'd6;
        Di    = 16'hDEAD;
        @(posedge CLK);
        #1;
        check_outputs("mid_rst_strobes");
        READ  = 1'b0;
        WRITE = 1'b0;
        #2;
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle("post_rst_wr", 1'b0, 1'b1, AW'(i), 16'hE000 + 16'(i));
            chk("post_rst_full", {15'd0, FULL}, {15'd0, (i == 7)});
        end
        cycle("post_rst_rd6", 1'b1, 1'b0, 3'd6, 16'h0);
        chk("post_rst_rd6_val", Do, 16'hE006);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
